// File: rtl/cm_pkg.sv
// rtl/cm_pkg.sv - shared constants and helpers for the cm sorter network
package cm_pkg;

   // Widest word the min/max helpers handle; words are zero-extended to this width.
   localparam int CM_WORD_W = 64;

   // Stage index after which register rank k (1..rc) is placed.
   function automatic int cm_rank_stage(input int k, input int dc, input int rc);
      return (k * dc) / rc - 1;
   endfunction

   // True when some register rank sits directly after stage s.
   function automatic bit cm_is_rank_stage(input int s, input int dc, input int rc);
      bit hit;
      hit = 1'b0;
      for (int k = 1; k <= rc; k++) begin
         if (cm_rank_stage(k, dc, rc) == s) hit = 1'b1;
      end
      return hit;
   endfunction

   // Unsigned minimum of two words.
   function automatic logic [CM_WORD_W-1:0] cm_umin(input logic [CM_WORD_W-1:0] a,
                                                    input logic [CM_WORD_W-1:0] b);
      return (b < a) ? b : a;
   endfunction

   // Unsigned maximum of two words.
   function automatic logic [CM_WORD_W-1:0] cm_umax(input logic [CM_WORD_W-1:0] a,
                                                    input logic [CM_WORD_W-1:0] b);
      return (b < a) ? a : b;
   endfunction

endpackage

// File: rtl/cm_cmp_swap.sv
// rtl/cm_cmp_swap.sv - unsigned compare-exchange cell, purely combinational
module cm_cmp_swap
   import cm_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] lo,
   output logic [DATA_WIDTH-1:0] hi
);

   // Zero-extension keeps the comparison unsigned; equal words come out unchanged.
   assign lo = DATA_WIDTH'(cm_umin(CM_WORD_W'(a), CM_WORD_W'(b)));
   assign hi = DATA_WIDTH'(cm_umax(CM_WORD_W'(a), CM_WORD_W'(b)));

endmodule

// File: rtl/cm_sorter.sv
// rtl/cm_sorter.sv - pipelined odd-even transposition sorter, ascending output
module cm_sorter
   import cm_pkg::*;
#(
   parameter int DATA_CNT   = 4,
   parameter int DATA_WIDTH = 16,
   parameter int REG_CNT    = 1
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_vld,
   input  logic [DATA_CNT-1:0][DATA_WIDTH-1:0] i_data,
   output logic                               o_vld,
   output logic [DATA_CNT-1:0][DATA_WIDTH-1:0] o_data
);

   // One block per network stage: input select, compare-exchange row, then a rank or a wire.
   for (genvar s = 0; s < DATA_CNT; s++) begin : g_stage
      logic [DATA_WIDTH-1:0] d_in  [DATA_CNT];
      logic                  v_in;
      logic [DATA_WIDTH-1:0] cx    [DATA_CNT];
      logic [DATA_WIDTH-1:0] d_out [DATA_CNT];
      logic                  v_out;

      if (s == 0) begin : g_src
         for (genvar j = 0; j < DATA_CNT; j++) begin : g_w
            assign d_in[j] = i_data[j];
         end
         assign v_in = i_vld;
      end else begin : g_src
         for (genvar j = 0; j < DATA_CNT; j++) begin : g_w
            assign d_in[j] = g_stage[s-1].d_out[j];
         end
         assign v_in = g_stage[s-1].v_out;
      end

      // Even stages pair (0,1),(2,3)..; odd stages pair (1,2),(3,4)..; leftovers pass through.
      for (genvar j = 0; j < DATA_CNT; j++) begin : g_pair
         if (((j % 2) == (s % 2)) && (j + 1 < DATA_CNT)) begin : g_cs
            cm_cmp_swap #(
               .DATA_WIDTH(DATA_WIDTH)
            ) u_cmp_swap (
               .a (d_in[j]),
               .b (d_in[j+1]),
               .lo(cx[j]),
               .hi(cx[j+1])
            );
         end else if (!((j >= 1) && (((j - 1) % 2) == (s % 2)))) begin : g_pass
            assign cx[j] = d_in[j];
         end
      end

      if (cm_is_rank_stage(s, DATA_CNT, REG_CNT)) begin : g_reg
         // Register rank: data loads every cycle, vld travels alongside it.
         always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
               for (int j = 0; j < DATA_CNT; j++) d_out[j] <= '0;
               v_out <= 1'b0;
            end else begin
               for (int j = 0; j < DATA_CNT; j++) d_out[j] <= cx[j];
               v_out <= v_in;
            end
         end
      end else begin : g_wire
         for (genvar j = 0; j < DATA_CNT; j++) begin : g_w
            assign d_out[j] = cx[j];
         end
         assign v_out = v_in;
      end
   end

   // The last stage always carries a rank, so these outputs come straight from flops.
   for (genvar j = 0; j < DATA_CNT; j++) begin : g_out
      assign o_data[j] = g_stage[DATA_CNT-1].d_out[j];
   end
   assign o_vld = g_stage[DATA_CNT-1].v_out;

endmodule

// File: tb/tb_cm_sorter.sv
// tb/tb_cm_sorter.sv - scoreboard bench for cm_sorter in three configurations
module tb_cm_sorter;

   localparam int RA = 1;   // config A: 4 words, 1 rank
   localparam int RB = 4;   // config B: 6 words, 4 ranks (uneven placement)
   localparam int RC = 5;   // config C: 5 words, 5 ranks (odd count, one stage per rank)

   typedef struct {
      logic [127:0] d;
      int           c;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   logic               a_vld, a_ovld;
   logic [3:0][15:0]   a_data, a_odata;
   logic               b_vld, b_ovld;
   logic [5:0][15:0]   b_data, b_odata;
   logic               c_vld, c_ovld;
   logic [4:0][15:0]   c_data, c_odata;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   cm_sorter #(.DATA_CNT(4), .DATA_WIDTH(16), .REG_CNT(RA)) u_dut_a (
      .i_clk(clk), .i_rst(rst_n), .i_vld(a_vld), .i_data(a_data), .o_vld(a_ovld), .o_data(a_odata));
   cm_sorter #(.DATA_CNT(6), .DATA_WIDTH(16), .REG_CNT(RB)) u_dut_b (
      .i_clk(clk), .i_rst(rst_n), .i_vld(b_vld), .i_data(b_data), .o_vld(b_ovld), .o_data(b_odata));
   cm_sorter #(.DATA_CNT(5), .DATA_WIDTH(16), .REG_CNT(RC)) u_dut_c (
      .i_clk(clk), .i_rst(rst_n), .i_vld(c_vld), .i_data(c_data), .o_vld(c_ovld), .o_data(c_odata));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [127:0] bsort(input logic [127:0] v, input int n);
      logic [15:0]  w [8];
      logic [15:0]  t;
      logic [127:0] r;
      for (int i = 0; i < 8; i++) w[i] = (i < n) ? v[16*i +: 16] : 16'h0;
      for (int p = 0; p < n; p++)
         for (int i = 0; i + 1 < n; i++)
            if (w[i] > w[i+1]) begin
               t = w[i]; w[i] = w[i+1]; w[i+1] = t;
            end
      r = '0;
      for (int i = 0; i < n; i++) r[16*i +: 16] = w[i];
      return r;
   endfunction

   function automatic logic [127:0] rvec();
      logic [127:0] v;
      int           m;
      m = $urandom_range(0, 1);
      for (int i = 0; i < 8; i++) begin
         case (m == 0 ? 3 : $urandom_range(0, 3))
            0:       v[16*i +: 16] = 16'h0000;
            1:       v[16*i +: 16] = 16'hFFFF;
            default: v[16*i +: 16] = 16'($urandom);
         endcase
      end
      return v;
   endfunction

   // mode 0 ascending, 1 descending, 2 all 0x5A5A
   function automatic logic [127:0] pvec(input int n, input int mode);
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < n; i++)
         v[16*i +: 16] = (mode == 0) ? 16'(i * 100 + 7) :
                         (mode == 1) ? 16'((n - i) * 100 + 7) : 16'h5A5A;
      return v;
   endfunction

   task automatic put_a(input logic [127:0] v);
      a_vld = 1'b1; a_data = v[63:0];
      qa.push_back('{d: bsort(v, 4), c: cyc + RA});
   endtask

   task automatic put_b(input logic [127:0] v);
      b_vld = 1'b1; b_data = v[95:0];
      qb.push_back('{d: bsort(v, 6), c: cyc + RB});
   endtask

   task automatic put_c(input logic [127:0] v);
      c_vld = 1'b1; c_data = v[79:0];
      qc.push_back('{d: bsort(v, 5), c: cyc + RC});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
   endtask

   // Output monitors: every o_vld must match the oldest pending expectation, at its due cycle.
   always @(negedge clk) begin
      if (rst_n && a_ovld) begin
         if (qa.size() == 0) check("a_spurious_vld", 1, 0);
         else begin
            exp_t e;
            e = qa.pop_front();
            check("a_data", {64'b0, a_odata}, e.d);
            check("a_latency", cyc, e.c);
         end
      end
      if (rst_n && b_ovld) begin
         if (qb.size() == 0) check("b_spurious_vld", 1, 0);
         else begin
            exp_t e;
            e = qb.pop_front();
            check("b_data", {32'b0, b_odata}, e.d);
            check("b_latency", cyc, e.c);
         end
      end
      if (rst_n && c_ovld) begin
         if (qc.size() == 0) check("c_spurious_vld", 1, 0);
         else begin
            exp_t e;
            e = qc.pop_front();
            check("c_data", {48'b0, c_odata}, e.d);
            check("c_latency", cyc, e.c);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a_vld = 1'b0; a_data = '0;
      b_vld = 1'b0; b_data = '0;
      c_vld = 1'b0; c_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_vld", a_ovld, 0);
      check("rst_a_data", a_odata, 0);
      check("rst_b_vld", b_ovld, 0);
      check("rst_b_data", b_odata, 0);
      check("rst_c_vld", c_ovld, 0);
      check("rst_c_data", c_odata, 0);
      rst_n = 1'b1;

      // Worked example: {3,1,4,2} -> {1,2,3,4}, one cycle later, single-cycle o_vld.
      put_a({16'd2, 16'd4, 16'd1, 16'd3});
      tick();
      check("t1_vld", a_ovld, 1);
      check("t1_data", a_odata, 64'h0004_0003_0002_0001);
      tick();
      check("t1_pulse_len", a_ovld, 0);

      // Extremes on six words: sign bit and all-ones must sort as unsigned.
      put_b({16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF});
      repeat (RB) tick();
      check("t3_vld", b_ovld, 1);
      check("t3_data", b_odata, 96'hFFFF_FFFF_8000_0001_0000_0000);
      repeat (4) tick();

      // Back-to-back bursts of three on every configuration.
      for (int k = 0; k < 3; k++) begin
         put_a(rvec()); put_b(rvec()); put_c(rvec());
         tick();
      end
      repeat (8) tick();

      // Ascending, descending and all-equal patterns.
      for (int m = 0; m < 3; m++) begin
         put_a(pvec(4, m)); put_b(pvec(6, m)); put_c(pvec(5, m));
         tick();
      end
      repeat (8) tick();

      // Random traffic with irregular gaps.
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 2) != 0) put_a(rvec());
         if ($urandom_range(0, 2) != 0) put_b(rvec());
         if ($urandom_range(0, 2) != 0) put_c(rvec());
         tick();
      end
      repeat (8) tick();

      // Reset with two vectors in flight in config B: outputs clear at once, nothing emerges.
      put_b(rvec());
      tick();
      put_b(rvec());
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_b_vld", b_ovld, 0);
      check("midrst_b_data", b_odata, 0);
      check("midrst_a_vld", a_ovld, 0);
      qb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) tick();

      // First edge after release accepts a vector.
      put_b(rvec()); put_c(rvec());
      tick();
      repeat (8) tick();

      check("a_drain", qa.size(), 0);
      check("b_drain", qb.size(), 0);
      check("c_drain", qc.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
